counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the bit width of cnt_init and cnt.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port cnt_init, input, WIDTH bits: start value, sampled only on an accepted start.
REQ-005 The block SHALL have port start, input, 1 bit: a request to load cnt_init and begin counting down.
REQ-006 The block SHALL have port cnt, output, WIDTH bits: current count value, driven directly from a register.
REQ-007 The block SHALL have port ready, output, 1 bit: high when the block is idle and will accept start.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when a count sequence completes.

Function
REQ-009 The block SHALL implement a two-state FSM with states IDLE and COUNT.
REQ-010 ready SHALL equal (state == IDLE), decoded combinationally from the state register.
REQ-011 In IDLE, a rising clock edge with start=1 SHALL load cnt <= cnt_init.
REQ-012 On that accepting edge, if cnt_init != 0, the next state SHALL be COUNT.
REQ-013 In IDLE with start=1 and cnt_init == 0, the block SHALL load cnt <= 0, pulse done for the next cycle, and stay in IDLE.
REQ-014 In IDLE with start=0, cnt SHALL hold its value.
REQ-015 In COUNT, each rising edge SHALL decrement cnt by 1.
REQ-016 In COUNT, the edge on which cnt is 1 SHALL set cnt <= 0, state <= IDLE and done <= 1.
REQ-017 done SHALL be registered, high for exactly one cycle, and 0 at all other times.
REQ-018 cnt SHALL never wrap below 0; the terminal value is 0.
REQ-019 start SHALL be ignored while in COUNT; cnt_init changes during COUNT SHALL have no effect.
REQ-020 Latency from an accepting edge with cnt_init=N (N>0) to the done pulse SHALL be N cycles; cnt reads N, N-1, ..., 0 on successive cycles.
REQ-021 start held high continuously SHALL be accepted again on the first edge after returning to IDLE.
REQ-022 Arithmetic SHALL be unsigned WIDTH-bit; cnt_init = 2^WIDTH-1 SHALL count down fully without overflow.

Reset
REQ-023 While rst=0, regardless of clk: state SHALL be IDLE, cnt SHALL be 0, done SHALL be 0, and ready SHALL be 1.
REQ-024 Reset asserted during COUNT SHALL abort the sequence immediately with no done pulse.
REQ-025 After rst deasserts, the first rising edge SHALL apply normal IDLE behaviour.

Structure
REQ-026 A shared package counter_pkg SHALL hold the state enum type (IDLE, COUNT) and the default WIDTH constant.
REQ-027 The block SHALL be a single module with no sub-modules: one sequential block for state, cnt and done, plus combinational next-state and ready logic.

Verification
REQ-028 Reset test: hold rst=0 for 2 cycles -> cnt=0, ready=1, done=0 throughout.
REQ-029 Basic count: release reset, then on 1 edge apply start=1 and cnt_init=10, then start=0 -> cnt reads 10,9,...,0 over 11 cycles; done pulses once when cnt becomes 0; ready returns to 1; cnt holds 0 for the following 4 cycles.
REQ-030 Zero load: start=1 with cnt_init=0 in IDLE -> cnt=0, done pulses one cycle, ready stays 1.
REQ-031 Ignored start: start=1 with cnt_init=99 mid-count of 5 -> sequence unaffected (5..0), then 99 is accepted on the first edge in IDLE if start is still high.
REQ-032 Abort: assert rst=0 when cnt=4 -> cnt=0 and ready=1 asynchronously; no done pulse follows.
REQ-033 Back-to-back: start held high with cnt_init=3 -> repeating 3,2,1,0,3,2,1,0 with done on each 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and defaults for the down-counter.
// Holds the FSM state encoding and the default counter width.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

endpackage

// File: rtl/counter.sv
// Loadable down-counter: accepted start with N>0 gives done N cycles later (N=0: next cycle).
// start is ignored while counting (ready=0); no other backpressure.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_init,
    input  logic             start,
    output logic [WIDTH-1:0] cnt,
    output logic             ready,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = cnt_init;
                    if (cnt_init != '0) begin
                        state_d = COUNT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            COUNT: begin
                // Terminate on 1 (guarding 0 too) so cnt can never wrap.
                if (cnt_q <= WIDTH'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cnt   = cnt_q;
    assign done  = done_q;
    assign ready = (state_q == IDLE);

endmodule

// File: tb/tb_counter.sv
// Directed plus randomized checks of counter against a queue-based reference model.
module tb_counter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] cnt_init;
    logic         start;
    logic [W-1:0] cnt;
    logic         ready;
    logic         done;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference: values cnt will still show after the current one while busy.
    logic [W-1:0] pend_q[$];
    logic [W-1:0] exp_cnt;
    logic         exp_done;

    counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_init (cnt_init),
        .start    (start),
        .cnt      (cnt),
        .ready    (ready),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_model();
        pend_q.delete();
        exp_cnt  = '0;
        exp_done = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic [W-1:0] init);
        if (!rst) begin
            reset_model();
        end else begin
            exp_done = 1'b0;
            if (pend_q.size() != 0) begin
                exp_cnt  = pend_q.pop_front();
                exp_done = (exp_cnt == '0);
            end else if (s) begin
                exp_cnt = init;
                for (int v = int'(init) - 1; v >= 0; v--) pend_q.push_back(W'(v));
                exp_done = (init == '0);
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_ready;
        exp_ready = (pend_q.size() == 0);
        n_vec++;
        assert (cnt === exp_cnt) else begin
            n_miss++;
            $error("FAIL %s cnt: got %0d expected %0d", tag, cnt, exp_cnt);
        end
        n_vec++;
        assert (done === exp_done) else begin
            n_miss++;
            $error("FAIL %s done: got %b expected %b", tag, done, exp_done);
        end
        n_vec++;
        assert (ready === exp_ready) else begin
            n_miss++;
            $error("FAIL %s ready: got %b expected %b", tag, ready, exp_ready);
        end
    endtask

    task automatic step(input logic s, input logic [W-1:0] init, input string tag);
        start    = s;
        cnt_init = init;
        @(posedge clk);
        model_edge(s, init);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        cnt_init = '0;
        reset_model();
        #3;
        check_all("rst_async");

        // Reset held across edges with start requested: nothing may happen.
        repeat (2) step(1'b1, 8'd77, "rst_hold");
        rst = 1'b1;

        // Basic countdown of 10 followed by 4 idle hold cycles.
        step(1'b1, 8'd10, "basic_load");
        repeat (14) step(1'b0, W'($urandom), "basic_run");

        // Zero load completes immediately.
        step(1'b1, 8'd0, "zero_load");
        repeat (2) step(1'b0, 8'd0, "zero_after");

        // Start held with a new value mid-count, then accepted once idle.
        step(1'b1, 8'd5, "ign_load");
        repeat (5) step(1'b1, 8'd99, "ign_run");
        step(1'b1, 8'd99, "ign_accept");
        repeat (100) step(1'b0, W'($urandom), "ign_99");

        // Asynchronous abort while cnt is 4.
        step(1'b1, 8'd6, "abort_load");
        repeat (2) step(1'b0, 8'd0, "abort_run");
        #3 rst = 1'b0;
        #1;
        reset_model();
        check_all("abort_async");
        rst = 1'b1;
        repeat (3) step(1'b0, 8'd0, "abort_after");

        // Back-to-back with start held high.
        repeat (12) step(1'b1, 8'd3, "b2b");
        repeat (2) step(1'b0, 8'd0, "b2b_tail");

        // Full-scale countdown from the maximum value.
        step(1'b1, 8'd255, "max_load");
        repeat (257) step(1'b0, W'($urandom), "max_run");

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            logic         s;
            logic [W-1:0] init;
            s    = ($urandom_range(0, 2) == 0);
            init = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b0;
                #1;
                reset_model();
                check_all("rand_rst");
                rst = 1'b1;
            end
            step(s, init, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
